// File: rtl/bmem_fetch_buffer.sv
// Instruction prefetch buffer between IF and boot memory: fetches sequential words into an
// address-tagged FIFO, serves IF hits from the head, and retries fetches dropped by the port.
module bmem_fetch_buffer #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] BMEM_BASE = 32'h0000_1000,
  parameter logic [XLEN-1:0] BMEM_SIZE = 32'h0000_1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  input  logic            if_kill_i,
  output logic            if_ack_o,
  output logic [XLEN-1:0] if_rdata_o,
  output logic            bmem_req_o,
  output logic [XLEN-1:0] bmem_addr_o,
  input  logic            bmem_ack_i,
  input  logic [XLEN-1:0] bmem_rdata_i
);

  localparam int unsigned     PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW      = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] InstrNop  = XLEN'(32'h0000_0013);
  localparam logic [XLEN:0]   RegionEnd = {1'b0, BMEM_BASE} + {1'b0, BMEM_SIZE};

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e          st_q, st_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic            run_q, run_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            if_ack_q, if_ack_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] fifo_addr_q [DEPTH];
  logic [XLEN-1:0] fifo_data_q [DEPTH];

  logic            eval, hit, pending, redirect, flush, push;
  logic [XLEN:0]   fetch_inc;

  function automatic logic in_region(input logic [XLEN-1:0] a);
    return (a >= BMEM_BASE) && ({1'b0, a} < RegionEnd);
  endfunction

  // A request is not re-evaluated while its ack is showing, so a held request cannot pop twice.
  assign eval      = if_req_i & ~if_ack_q & ~if_kill_i;
  assign hit       = eval && (count_q != '0) && (fifo_addr_q[rd_ptr_q] == if_addr_i);
  assign pending   = eval && (count_q == '0) && (st_q != StIdle) && (fetch_addr_q == if_addr_i);
  assign redirect  = eval && !hit && !pending && in_region(if_addr_i);
  assign flush     = if_kill_i | redirect;
  assign push      = (st_q == StResp) && bmem_ack_i && !flush;
  assign fetch_inc = {1'b0, fetch_addr_q} + (XLEN+1)'(4);

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    run_d        = run_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (hit)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(hit);
    end
    // Prefetch only runs between a redirect and the next kill or address-space carry.
    if (if_kill_i) begin
      run_d = 1'b0;
    end else if (redirect) begin
      fetch_addr_d = if_addr_i;
      run_d        = 1'b1;
    end else if (push) begin
      fetch_addr_d = fetch_inc[XLEN-1:0];
      if (fetch_inc[XLEN]) run_d = 1'b0;
    end
    if_ack_d   = hit;
    if_rdata_d = hit ? fifo_data_q[rd_ptr_q] : if_rdata_q;
  end

  always_comb begin
    st_d = st_q;
    if (if_kill_i) begin
      st_d = StIdle;
    end else if (redirect) begin
      st_d = StIssue;
    end else begin
      unique case (st_q)
        StIdle: begin
          if ((count_q < CntW'(DEPTH)) && run_q && in_region(fetch_addr_q)) st_d = StIssue;
        end
        StIssue: st_d = StResp;
        StResp: begin
          if (!bmem_ack_i) begin
            st_d = StIssue;
          end else if ((count_d < CntW'(DEPTH)) && run_d && in_region(fetch_addr_d)) begin
            st_d = StIssue;
          end else begin
            st_d = StIdle;
          end
        end
        default: st_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bmem_req_o  = (st_q == StIssue);
    bmem_addr_o = (st_q == StIssue) ? fetch_addr_q : '0;
    if_ack_o    = if_ack_q;
    if_rdata_o  = if_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q         <= StIdle;
      fetch_addr_q <= '0;
      run_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      if_ack_q     <= 1'b0;
      if_rdata_q   <= InstrNop;
    end else begin
      st_q         <= st_d;
      fetch_addr_q <= fetch_addr_d;
      run_q        <= run_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      if_ack_q     <= if_ack_d;
      if_rdata_q   <= if_rdata_d;
    end
  end

  // Entry contents need no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_addr_q[wr_ptr_q] <= fetch_addr_q;
      fifo_data_q[wr_ptr_q] <= bmem_rdata_i;
    end
  end

endmodule

// File: tb/tb_bmem_fetch_buffer.sv
// Directed bench for bmem_fetch_buffer: a per-cycle vector table for cold fetch and streaming,
// then hand-written sequences for port collisions, redirect, kill, region end and reset.
module tb_bmem_fetch_buffer;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_kill_i = 1'b0;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        bmem_req_o;
  logic [31:0] bmem_addr_o;
  logic        bmem_ack_i = 1'b0;
  logic [31:0] bmem_rdata_i = '0;

  int total = 0;
  int bad = 0;

  bmem_fetch_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_kill_i    (if_kill_i),
    .if_ack_o     (if_ack_o),
    .if_rdata_o   (if_rdata_o),
    .bmem_req_o   (bmem_req_o),
    .bmem_addr_o  (bmem_addr_o),
    .bmem_ack_i   (bmem_ack_i),
    .bmem_rdata_i (bmem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        kill;
    logic        back;
    logic [31:0] bdata;
    logic        e_ack;
    logic [31:0] e_rdata;
    logic        e_breq;
    logic [31:0] e_baddr;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic kill,
                              input logic back, input logic [31:0] bdata, input logic e_ack,
                              input logic [31:0] e_rdata, input logic e_breq,
                              input logic [31:0] e_baddr);
    vec_t v;
    v.req = req; v.addr = addr; v.kill = kill; v.back = back; v.bdata = bdata;
    v.e_ack = e_ack; v.e_rdata = e_rdata; v.e_breq = e_breq; v.e_baddr = e_baddr;
    return v;
  endfunction

  // Apply inputs at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic drive(input logic req, input logic [31:0] addr, input logic kill,
                       input logic back, input logic [31:0] bdata);
    if_req_i     = req;
    if_addr_i    = addr;
    if_kill_i    = kill;
    bmem_ack_i   = back;
    bmem_rdata_i = bdata;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic e_ack, input logic [31:0] e_rdata,
                       input logic e_breq, input logic [31:0] e_baddr);
    total++;
    if (if_ack_o !== e_ack || if_rdata_o !== e_rdata || bmem_req_o !== e_breq ||
        bmem_addr_o !== e_baddr) begin
      bad++;
      $display("FAIL %s: got ack=%0b rdata=%h breq=%0b baddr=%h, want ack=%0b rdata=%h breq=%0b baddr=%h",
               name, if_ack_o, if_rdata_o, bmem_req_o, bmem_addr_o,
               e_ack, e_rdata, e_breq, e_baddr);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Cold fetch from 0x1000, fill to four entries, then stream hits up to 0x101C.
    vecs[0]  = mk(1, 32'h1000, 0, 0, 0,        0, Nop,      1, 32'h1000);
    vecs[1]  = mk(1, 32'h1000, 0, 0, 0,        0, Nop,      0, 32'h0);
    vecs[2]  = mk(1, 32'h1000, 0, 1, 32'hA0,   0, Nop,      1, 32'h1004);
    vecs[3]  = mk(1, 32'h1000, 0, 0, 0,        1, 32'hA0,   0, 32'h0);
    vecs[4]  = mk(1, 32'h1000, 0, 1, 32'hA1,   0, 32'hA0,   1, 32'h1008);
    vecs[5]  = mk(0, 32'h0,    0, 0, 0,        0, 32'hA0,   0, 32'h0);
    vecs[6]  = mk(0, 32'h0,    0, 1, 32'hA2,   0, 32'hA0,   1, 32'h100C);
    vecs[7]  = mk(0, 32'h0,    0, 0, 0,        0, 32'hA0,   0, 32'h0);
    vecs[8]  = mk(0, 32'h0,    0, 1, 32'hA3,   0, 32'hA0,   1, 32'h1010);
    vecs[9]  = mk(0, 32'h0,    0, 0, 0,        0, 32'hA0,   0, 32'h0);
    vecs[10] = mk(0, 32'h0,    0, 1, 32'hA4,   0, 32'hA0,   0, 32'h0);
    vecs[11] = mk(0, 32'h0,    0, 1, 32'hFF,   0, 32'hA0,   0, 32'h0);
    vecs[12] = mk(1, 32'h1004, 0, 0, 0,        1, 32'hA1,   0, 32'h0);
    vecs[13] = mk(1, 32'h1008, 0, 0, 0,        0, 32'hA1,   1, 32'h1014);
    vecs[14] = mk(1, 32'h1008, 0, 0, 0,        1, 32'hA2,   0, 32'h0);
    vecs[15] = mk(1, 32'h100C, 0, 1, 32'hA5,   0, 32'hA2,   1, 32'h1018);
    vecs[16] = mk(1, 32'h100C, 0, 0, 0,        1, 32'hA3,   0, 32'h0);
    vecs[17] = mk(1, 32'h1010, 0, 1, 32'hA6,   0, 32'hA3,   1, 32'h101C);
    vecs[18] = mk(1, 32'h1010, 0, 0, 0,        1, 32'hA4,   0, 32'h0);
    vecs[19] = mk(1, 32'h1014, 0, 0, 0,        0, 32'hA4,   1, 32'h101C);
    vecs[20] = mk(1, 32'h1014, 0, 0, 0,        1, 32'hA5,   0, 32'h0);
    vecs[21] = mk(1, 32'h1018, 0, 1, 32'hA7,   0, 32'hA5,   1, 32'h1020);
    vecs[22] = mk(1, 32'h1018, 0, 0, 0,        1, 32'hA6,   0, 32'h0);
    vecs[23] = mk(1, 32'h101C, 0, 1, 32'hA8,   0, 32'hA6,   1, 32'h1024);
    vecs[24] = mk(1, 32'h101C, 0, 0, 0,        1, 32'hA7,   0, 32'h0);
    vecs[25] = mk(0, 32'h0,    0, 0, 0,        0, 32'hA7,   1, 32'h1024);

    @(negedge clk);
    do_reset();
    check("reset_state", 0, Nop, 0, 32'h0);

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].req, vecs[i].addr, vecs[i].kill, vecs[i].back, vecs[i].bdata);
      check($sformatf("vec%0d", i), vecs[i].e_ack, vecs[i].e_rdata, vecs[i].e_breq,
            vecs[i].e_baddr);
    end

    // Port lost twice on 0x1008: reissued twice, stored exactly once.
    do_reset();
    drive(1, 32'h1008, 0, 0, 0);      check("col_issue", 0, Nop, 1, 32'h1008);
    drive(1, 32'h1008, 0, 0, 0);      check("col_resp", 0, Nop, 0, 32'h0);
    drive(1, 32'h1008, 0, 0, 0);      check("col_retry1", 0, Nop, 1, 32'h1008);
    drive(1, 32'h1008, 0, 0, 0);
    drive(1, 32'h1008, 0, 0, 0);      check("col_retry2", 0, Nop, 1, 32'h1008);
    drive(1, 32'h1008, 0, 0, 0);
    drive(1, 32'h1008, 0, 1, 32'hC2); check("col_push", 0, Nop, 1, 32'h100C);
    drive(1, 32'h1008, 0, 0, 0);      check("col_hit", 1, 32'hC2, 0, 32'h0);
    drive(1, 32'h100C, 0, 1, 32'hC3); check("col_next", 0, 32'hC2, 1, 32'h1010);
    drive(1, 32'h100C, 0, 0, 0);      check("col_once", 1, 32'hC3, 0, 32'h0);

    // Fill 0x1000..0x100C without consuming, then redirect to 0x1800.
    do_reset();
    drive(1, 32'h1000, 0, 0, 0);
    for (int n = 0; n < 4; n++) begin
      drive(0, 32'h0, 0, 0, 0);
      drive(0, 32'h0, 0, 1, 32'hB0 + 32'(n));
    end
    check("rd_full", 0, Nop, 0, 32'h0);
    drive(0, 32'h0, 0, 0, 0);         check("rd_idle", 0, Nop, 0, 32'h0);
    drive(1, 32'h1800, 0, 0, 0);      check("rd_issue", 0, Nop, 1, 32'h1800);
    drive(1, 32'h1800, 0, 0, 0);      check("rd_pend", 0, Nop, 0, 32'h0);
    drive(1, 32'h1800, 0, 1, 32'hD0); check("rd_push", 0, Nop, 1, 32'h1804);
    drive(1, 32'h1800, 0, 0, 0);      check("rd_hit", 1, 32'hD0, 0, 32'h0);
    drive(1, 32'h1800, 0, 0, 0);      check("rd_hold", 0, 32'hD0, 1, 32'h1804);
    drive(1, 32'h1000, 0, 0, 0);      check("rd_flushed", 0, 32'hD0, 1, 32'h1000);

    // Reset asserted in RESP with an ack present; later acks must be ignored.
    drive(0, 32'h0, 0, 0, 0);
    rst_n = 1'b0;
    drive(0, 32'h0, 0, 1, 32'hE5);    check("rst_resp", 0, Nop, 0, 32'h0);
    rst_n = 1'b1;
    drive(0, 32'h0, 0, 1, 32'hE6);
    drive(0, 32'h0, 0, 1, 32'hE7);    check("rst_ign", 0, Nop, 0, 32'h0);
    drive(1, 32'h1000, 0, 0, 0);      check("rst_after", 0, Nop, 1, 32'h1000);

    // Kill in RESP with ack: nothing pushed, stays idle until a new request.
    do_reset();
    drive(1, 32'h1000, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0);
    drive(0, 32'h0, 1, 1, 32'hE0);    check("kill_resp", 0, Nop, 0, 32'h0);
    drive(0, 32'h0, 0, 1, 32'hE1);    check("kill_idle1", 0, Nop, 0, 32'h0);
    drive(0, 32'h0, 0, 0, 0);         check("kill_idle2", 0, Nop, 0, 32'h0);
    drive(1, 32'h1004, 0, 0, 0);      check("kill_restart", 0, Nop, 1, 32'h1004);
    drive(1, 32'h1004, 0, 0, 0);
    drive(1, 32'h1004, 0, 1, 32'hE4);
    drive(1, 32'h1004, 0, 0, 0);      check("kill_hit", 1, 32'hE4, 0, 32'h0);

    // Region end: only two words from BASE+SIZE-8; outside-region requests ignored.
    do_reset();
    drive(1, 32'h1FF8, 0, 0, 0);      check("re_issue", 0, Nop, 1, 32'h1FF8);
    drive(0, 32'h0, 0, 0, 0);
    drive(0, 32'h0, 0, 1, 32'hF0);    check("re_second", 0, Nop, 1, 32'h1FFC);
    drive(0, 32'h0, 0, 0, 0);
    drive(0, 32'h0, 0, 1, 32'hF1);    check("re_stop", 0, Nop, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 32'h0, 0, 0, 0);       check($sformatf("re_quiet%0d", k), 0, Nop, 0, 32'h0);
    end
    drive(1, 32'h0800, 0, 0, 0);      check("re_oor1", 0, Nop, 0, 32'h0);
    drive(1, 32'h0800, 0, 0, 0);      check("re_oor2", 0, Nop, 0, 32'h0);
    drive(1, 32'h1FF8, 0, 0, 0);      check("re_hit", 1, 32'hF0, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
